// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
//   Generic inter-stage pipeline register (D/E, E/M, M/W). Carries an opaque
//   payload together with PC, branch-delay flag, exception code and a valid
//   bit. Supports hold (stall), plain bubble, PC-keeping bubble and exception
//   redirect, and provides optional saturating bubble/hold counters.
//
// Ports
//   clk         stage clock, rising edge
//   reset       asynchronous active-high reset
//   in_data     payload from previous stage (opaque)
//   in_pc       PC from previous stage
//   in_bd       branch-delay-slot flag from previous stage
//   in_exc      exception code from previous stage (0 = none)
//   in_valid    previous stage holds a real instruction
//   hold        keep current contents
//   flush       bubble, PC/bd forced to RESET_PC / 0
//   flush_keep  bubble that inherits in_pc / in_bd
//   req         exception/interrupt redirect
//   stat_clr    synchronous clear of both counters
//   out_*       registered copies of the fields above
//   bubble_cnt  bubbles inserted since last clear (saturating)
//   hold_cnt    hold cycles since last clear (saturating)
module pipe_stage_reg #(
  parameter int          DATA_W     = 128,
  parameter int          PC_W       = 32,
  parameter int          EXC_W      = 5,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          CNT_W      = 16,
  parameter bit          STATS_EN   = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic [PC_W-1:0]   in_pc,
  input  logic              in_bd,
  input  logic [EXC_W-1:0]  in_exc,
  input  logic              in_valid,
  input  logic              hold,
  input  logic              flush,
  input  logic              flush_keep,
  input  logic              req,
  input  logic              stat_clr,
  output logic [DATA_W-1:0] out_data,
  output logic [PC_W-1:0]   out_pc,
  output logic              out_bd,
  output logic [EXC_W-1:0]  out_exc,
  output logic              out_valid,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  hold_cnt
);

  localparam logic [PC_W-1:0] EXC_PC = PC_W'(EXC_VECTOR);
  localparam logic [PC_W-1:0] RST_PC = PC_W'(RESET_PC);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
  endfunction

  logic [DATA_W-1:0] data_nxt;
  logic [PC_W-1:0]   pc_nxt;
  logic              bd_nxt;
  logic [EXC_W-1:0]  exc_nxt;
  logic              vld_nxt;
  logic              ld_en;

  logic [DATA_W-1:0] data_p1;
  logic [PC_W-1:0]   pc_p1;
  logic              bd_p1;
  logic [EXC_W-1:0]  exc_p1;
  logic              vld_p1;

  logic              bubble_win;
  logic              hold_win;

  // Priority: req > flush > flush_keep > hold > load
  always_comb begin
    data_nxt = in_data;
    pc_nxt   = in_pc;
    bd_nxt   = in_bd;
    exc_nxt  = in_exc;
    vld_nxt  = in_valid;
    ld_en    = 1'b1;
    if (req) begin
      data_nxt = '0;
      exc_nxt  = '0;
      vld_nxt  = 1'b0;
      // A stall bubble in the same cycle keeps EPC/BD pointing at the
      // stalled instruction instead of the vector.
      if (flush_keep) begin
        pc_nxt = in_pc;
        bd_nxt = in_bd;
      end else begin
        pc_nxt = EXC_PC;
        bd_nxt = 1'b0;
      end
    end else if (flush) begin
      data_nxt = '0;
      exc_nxt  = '0;
      vld_nxt  = 1'b0;
      pc_nxt   = RST_PC;
      bd_nxt   = 1'b0;
    end else if (flush_keep) begin
      data_nxt = '0;
      exc_nxt  = '0;
      vld_nxt  = 1'b0;
    end else if (hold) begin
      ld_en = 1'b0;
    end
  end

  assign bubble_win = !req && (flush || flush_keep);
  assign hold_win   = hold && !req && !flush && !flush_keep;

  // Stage register p1
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_p1 <= '0;
      pc_p1   <= RST_PC;
      bd_p1   <= 1'b0;
      exc_p1  <= '0;
      vld_p1  <= 1'b0;
    end else if (ld_en) begin
      data_p1 <= data_nxt;
      pc_p1   <= pc_nxt;
      bd_p1   <= bd_nxt;
      exc_p1  <= exc_nxt;
      vld_p1  <= vld_nxt;
    end
  end

  assign out_data  = data_p1;
  assign out_pc    = pc_p1;
  assign out_bd    = bd_p1;
  assign out_exc   = exc_p1;
  assign out_valid = vld_p1;

  generate
    if (STATS_EN) begin : g_stats
      logic [CNT_W-1:0] bubble_cnt_p1;
      logic [CNT_W-1:0] hold_cnt_p1;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          bubble_cnt_p1 <= '0;
          hold_cnt_p1   <= '0;
        end else if (stat_clr) begin
          bubble_cnt_p1 <= '0;
          hold_cnt_p1   <= '0;
        end else begin
          if (bubble_win) bubble_cnt_p1 <= sat_inc(bubble_cnt_p1);
          if (hold_win)   hold_cnt_p1   <= sat_inc(hold_cnt_p1);
        end
      end

      assign bubble_cnt = bubble_cnt_p1;
      assign hold_cnt   = hold_cnt_p1;
    end else begin : g_no_stats
      logic unused_stats;
      assign unused_stats = stat_clr ^ bubble_win ^ hold_win;
      assign bubble_cnt   = '0;
      assign hold_cnt     = '0;
    end
  endgenerate

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Testbench for pipe_stage_reg: directed steps from the test plan followed by
// randomized traffic, compared against a rule-level reference model.
module tb_pipe_stage_reg;

  localparam int DATA_W = 128;
  localparam int PC_W   = 32;
  localparam int EXC_W  = 5;
  localparam int CNT_W  = 4;
  localparam int CMAX   = 15;

  logic              clk = 1'b0;
  logic              reset;
  logic [DATA_W-1:0] in_data;
  logic [PC_W-1:0]   in_pc;
  logic              in_bd;
  logic [EXC_W-1:0]  in_exc;
  logic              in_valid;
  logic              hold, flush, flush_keep, req, stat_clr;

  logic [DATA_W-1:0] out_data;
  logic [PC_W-1:0]   out_pc;
  logic              out_bd;
  logic [EXC_W-1:0]  out_exc;
  logic              out_valid;
  logic [CNT_W-1:0]  bubble_cnt, hold_cnt;

  logic [DATA_W-1:0] n_data;
  logic [PC_W-1:0]   n_pc;
  logic              n_bd;
  logic [EXC_W-1:0]  n_exc;
  logic              n_valid;
  logic [CNT_W-1:0]  n_bubble_cnt, n_hold_cnt;

  int checks   = 0;
  int failures = 0;

  // Reference state
  logic [DATA_W-1:0] m_data;
  logic [PC_W-1:0]   m_pc;
  logic              m_bd;
  logic [EXC_W-1:0]  m_exc;
  logic              m_valid;
  int                m_bub, m_hld;

  always #5 clk = ~clk;

  pipe_stage_reg #(.CNT_W(CNT_W), .STATS_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_pc(in_pc), .in_bd(in_bd),
    .in_exc(in_exc), .in_valid(in_valid), .hold(hold), .flush(flush),
    .flush_keep(flush_keep), .req(req), .stat_clr(stat_clr),
    .out_data(out_data), .out_pc(out_pc), .out_bd(out_bd), .out_exc(out_exc),
    .out_valid(out_valid), .bubble_cnt(bubble_cnt), .hold_cnt(hold_cnt)
  );

  pipe_stage_reg #(.CNT_W(CNT_W), .STATS_EN(1'b0)) dut_nostat (
    .clk(clk), .reset(reset), .in_data(in_data), .in_pc(in_pc), .in_bd(in_bd),
    .in_exc(in_exc), .in_valid(in_valid), .hold(hold), .flush(flush),
    .flush_keep(flush_keep), .req(req), .stat_clr(stat_clr),
    .out_data(n_data), .out_pc(n_pc), .out_bd(n_bd), .out_exc(n_exc),
    .out_valid(n_valid), .bubble_cnt(n_bubble_cnt), .hold_cnt(n_hold_cnt)
  );

  task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                       input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".data"},  out_data, m_data);
    check({tag, ".pc"},    DATA_W'(out_pc), DATA_W'(m_pc));
    check({tag, ".bd"},    DATA_W'(out_bd), DATA_W'(m_bd));
    check({tag, ".exc"},   DATA_W'(out_exc), DATA_W'(m_exc));
    check({tag, ".valid"}, DATA_W'(out_valid), DATA_W'(m_valid));
    check({tag, ".bubble_cnt"}, DATA_W'(bubble_cnt), DATA_W'(m_bub));
    check({tag, ".hold_cnt"},   DATA_W'(hold_cnt), DATA_W'(m_hld));
    check({tag, ".ns_pc"},      DATA_W'(n_pc), DATA_W'(m_pc));
    check({tag, ".ns_valid"},   DATA_W'(n_valid), DATA_W'(m_valid));
    check({tag, ".ns_cnts"},    DATA_W'({n_bubble_cnt, n_hold_cnt}), '0);
  endtask

  task automatic model_reset();
    m_data = '0; m_pc = '0; m_bd = 1'b0; m_exc = '0; m_valid = 1'b0;
    m_bub = 0; m_hld = 0;
  endtask

  // Apply the per-edge rules to the reference state using current inputs.
  task automatic model_edge();
    int bub_inc, hld_inc;
    bub_inc = 0;
    hld_inc = 0;
    if (req) begin
      m_data = '0; m_exc = '0; m_valid = 1'b0;
      m_pc = flush_keep ? in_pc : 32'h0000_4180;
      m_bd = flush_keep ? in_bd : 1'b0;
    end else if (flush) begin
      m_data = '0; m_exc = '0; m_valid = 1'b0; m_pc = '0; m_bd = 1'b0;
      bub_inc = 1;
    end else if (flush_keep) begin
      m_data = '0; m_exc = '0; m_valid = 1'b0; m_pc = in_pc; m_bd = in_bd;
      bub_inc = 1;
    end else if (hold) begin
      hld_inc = 1;
    end else begin
      m_data = in_data; m_pc = in_pc; m_bd = in_bd; m_exc = in_exc;
      m_valid = in_valid;
    end
    if (stat_clr) begin
      m_bub = 0;
      m_hld = 0;
    end else begin
      m_bub = (m_bub + bub_inc > CMAX) ? CMAX : m_bub + bub_inc;
      m_hld = (m_hld + hld_inc > CMAX) ? CMAX : m_hld + hld_inc;
    end
  endtask

  task automatic tick(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic ctl(input logic h, input logic f, input logic fk,
                     input logic r, input logic c);
    hold = h; flush = f; flush_keep = fk; req = r; stat_clr = c;
  endtask

  task automatic drive(input logic [PC_W-1:0] pc, input logic bd,
                       input logic [EXC_W-1:0] exc, input logic v,
                       input logic [DATA_W-1:0] d);
    in_pc = pc; in_bd = bd; in_exc = exc; in_valid = v; in_data = d;
  endtask

  function automatic logic [DATA_W-1:0] rnd_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    reset = 1'b1;
    ctl(0, 0, 0, 0, 0);
    drive('0, 0, '0, 0, '0);
    model_reset();
    @(posedge clk);
    #1;
    check_all("reset");
    #2 reset = 1'b0;

    // Load, then reset between edges
    drive(32'h3000, 0, '0, 1, 128'hA5);
    tick("load_3000");
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_all("reset_mid");
    @(posedge clk);
    #1;
    check_all("reset_held");
    #2 reset = 1'b0;

    // Plain load
    drive(32'h3004, 1, 5'd10, 1, 128'h1234);
    tick("load_3004");
    check("load_3004.pc_const", DATA_W'(out_pc), DATA_W'(32'h3004));

    // Hold for three edges with changing inputs
    drive(32'h3008, 0, 5'd3, 1, rnd_data());
    tick("load_3008");
    ctl(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive($urandom, 1'($urandom), 5'($urandom), 1'($urandom), rnd_data());
      tick("hold");
    end
    check("hold.cnt3", DATA_W'(hold_cnt), DATA_W'(3));
    check("hold.pc_const", DATA_W'(out_pc), DATA_W'(32'h3008));

    // Bubbles
    ctl(0, 0, 1, 0, 0);
    drive(32'h300C, 1, 5'd7, 1, rnd_data());
    tick("flush_keep");
    ctl(0, 1, 0, 0, 0);
    drive(32'h3010, 1, 5'd7, 1, rnd_data());
    tick("flush");
    check("flush.bub2", DATA_W'(bubble_cnt), DATA_W'(2));

    // req priority
    ctl(1, 1, 0, 1, 0);
    drive(32'h3014, 1, 5'd9, 1, rnd_data());
    tick("req_flush_hold");
    check("req.vector", DATA_W'(out_pc), DATA_W'(32'h4180));
    ctl(0, 0, 1, 1, 0);
    drive(32'h3010, 1, 5'd9, 1, rnd_data());
    tick("req_flush_keep");

    // Saturation and clear
    ctl(0, 0, 0, 0, 1);
    drive(32'h3020, 0, '0, 1, rnd_data());
    tick("clr");
    ctl(1, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) tick("hold_sat");
    check("hold_sat.15", DATA_W'(hold_cnt), DATA_W'(15));
    ctl(1, 0, 0, 0, 1);
    tick("clr_hold");
    ctl(1, 0, 0, 0, 0);
    tick("hold_after_clr");
    for (int i = 0; i < 17; i++) begin
      ctl(0, i[0], ~i[0], 0, 0);
      tick("bub_sat");
    end

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      ctl($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
          $urandom_range(0, 7) == 0, $urandom_range(0, 11) == 0,
          $urandom_range(0, 15) == 0);
      drive($urandom, 1'($urandom), 5'($urandom), 1'($urandom), rnd_data());
      tick("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic, parametrised inter-stage pipeline register. One instance replaces each hand-written D/E, E/M and M/W register.
- Carries an opaque payload bundle (instr, operands, register addresses, Tnew, control fields) plus PC, branch-delay flag, exception code and a valid bit.
- Handles hold (stall), bubble insertion, exception-request redirect, and optional saturating stall/bubble statistics counters for the CP0 performance hooks.

Parameters:
- DATA_W, 128, width of the opaque payload bundle.
- PC_W, 32, width of the PC field.
- EXC_W, 5, width of the exception-code field.
- EXC_VECTOR, 32'h0000_4180, PC value loaded when req is asserted.
- RESET_PC, 32'h0000_0000, PC value after reset and after a plain bubble.
- CNT_W, 16, width of each statistics counter.
- STATS_EN, 1, 1 = counters implemented; 0 = counter outputs tied to 0.

Ports:
- clk  in  1  stage clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_data  in  DATA_W  payload from the previous stage.
- in_pc  in  PC_W  PC from the previous stage.
- in_bd  in  1  branch-delay-slot flag from the previous stage.
- in_exc  in  EXC_W  exception code from the previous stage (0 = none).
- in_valid  in  1  previous stage holds a real instruction.
- hold  in  1  keep current contents (this stage stalled).
- flush  in  1  insert a bubble; PC and bd reset to RESET_PC / 0.
- flush_keep  in  1  insert a bubble that inherits in_pc and in_bd (stall bubble, keeps EPC/BD correct).
- req  in  1  exception/interrupt taken; redirect this stage.
- stat_clr  in  1  synchronous clear of both counters.
- out_data  out  DATA_W  registered payload.
- out_pc  out  PC_W  registered PC.
- out_bd  out  1  registered branch-delay flag.
- out_exc  out  EXC_W  registered exception code.
- out_valid  out  1  registered valid.
- bubble_cnt  out  CNT_W  bubbles inserted since the last clear.
- hold_cnt  out  CNT_W  cycles spent holding since the last clear.

Behaviour:
- Reset (async, active-high): out_data=0, out_pc=RESET_PC, out_bd=0, out_exc=0, out_valid=0, bubble_cnt=0, hold_cnt=0. Takes effect immediately, including mid-hold or mid-flush. Normal operation resumes on the first rising edge after deassertion.
- Per-edge priority (highest first): req > flush > flush_keep > hold > load.
- req: data=0, exc=0, valid=0, pc=EXC_VECTOR, bd=0. Exception: if flush_keep is also high, pc=in_pc and bd=in_bd (stall bubble beats the redirect PC).
- flush: data=0, exc=0, valid=0, pc=RESET_PC, bd=0.
- flush_keep: data=0, exc=0, valid=0, pc=in_pc, bd=in_bd.
- hold: every field retains its value. Inputs are ignored.
- load (none of the above): all fields capture their in_* inputs. out_valid = in_valid.
- Latency is exactly 1 cycle from input to output. No combinational path from any input to any output.
- bubble_cnt:
  - +1 on each edge where flush or flush_keep wins and req=0.
  - Edges won by req are not counted.
- hold_cnt: +1 on each edge where hold wins, i.e. hold=1 with req, flush and flush_keep all 0.
- Counter saturation: both counters stop at 2^CNT_W-1 and never wrap.
- stat_clr: both counters go to 0 on that edge. stat_clr overrides any increment in the same cycle.
- STATS_EN=0: both counters are constant 0 and stat_clr is ignored.
- Payload bits are opaque. No field inside in_data is interpreted.
- The exception code travels unmodified. Merging with local exceptions is done outside this block.

Test Plan:
- Reset mid-operation: load in_pc=0x3000, in_data=0xA5 (valid=1), assert reset between edges -> outputs drop immediately to pc=0, data=0, valid=0, counters 0.
- Plain load: in_pc=0x3004, in_bd=1, in_exc=5'd10, in_valid=1, in_data=0x1234 -> next edge outputs match exactly; one-cycle latency checked against a model.
- Hold: after loading pc=0x3008, drive hold=1 for 3 edges with changing inputs -> outputs stay at 0x3008; hold_cnt=3; bubble_cnt=0.
- Bubbles:
  - flush_keep with in_pc=0x300C, in_bd=1 -> data=0, valid=0, pc=0x300C, bd=1.
  - Then flush -> pc=0, bd=0.
  - bubble_cnt=2.
- req priority:
  - req=1 with flush=1 and hold=1 -> pc=0x4180, valid=0, exc=0; no counter changes.
  - req=1 with flush_keep=1, in_pc=0x3010 -> pc=0x3010.
- Saturation/clear with CNT_W=4:
  - 20 hold cycles -> hold_cnt=15.
  - stat_clr together with hold -> hold_cnt=0 on that edge, then 1 on the next hold edge.
